// File: rtl/glb_sram.sv
// Global buffer: byte-addressed, word-organised 1R1W SRAM with per-lane enables,
// write-first forwarding on a same-word collision and a registered read port.
module glb_sram #(
  parameter int DATA_SIZE   = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           re,
  input  logic [31:0]          r_addr,
  output logic [DATA_SIZE-1:0] dout,
  input  logic [3:0]           we,
  input  logic [31:0]          w_addr,
  input  logic [DATA_SIZE-1:0] din
);

  localparam int LANES = DATA_SIZE / 8;

  logic [DATA_SIZE-1:0] mem [0:DEPTH_WORDS-1];

  logic [ADDR_W-1:0]    r_idx;
  logic [ADDR_W-1:0]    w_idx;
  logic                 same_word;
  logic [DATA_SIZE-1:0] rd_word;
  logic [DATA_SIZE-1:0] next_dout;

  // Byte offset and high address bits are dropped, so addresses wrap silently.
  assign r_idx     = r_addr[ADDR_W+1:2];
  assign w_idx     = w_addr[ADDR_W+1:2];
  assign same_word = (r_idx == w_idx);
  assign rd_word   = mem[r_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_addr[31:ADDR_W+2], r_addr[1:0],
                              w_addr[31:ADDR_W+2], w_addr[1:0]};

  // NOTE: the array has no reset branch on purpose; clearing it would block SRAM
  // inference and wipe contents preloaded before reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) mem[w_idx][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // NOTE: every lane of next_dout is assigned on every path, so no latch is inferred.
  always_comb begin
    next_dout = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!re[i])
        next_dout[8*i +: 8] = 8'h00;
      else if (we[i] && same_word)
        next_dout[8*i +: 8] = din[8*i +: 8];
      else
        next_dout[8*i +: 8] = rd_word[8*i +: 8];
    end
  end

  // A cycle with no lane enabled is not a read, so dout keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dout <= '0;
    else if (|re)
      dout <= next_dout;
  end

endmodule

// File: tb/tb_glb_sram.sv
// Directed bench for glb_sram: the driver queues the expected read data, an
// independent monitor pops and compares it one edge after each observed cycle.
module tb_glb_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  re = '0;
  logic [31:0] r_addr = '0;
  logic [31:0] dout;
  logic [3:0]  we = '0;
  logic [31:0] w_addr = '0;
  logic [31:0] din = '0;

  logic        chk = 1'b0;
  string       chk_name = "";
  logic [31:0] exp_q [$];
  string       name_q [$];

  int n_vec = 0;
  int n_err = 0;

  glb_sram dut (
    .clk    (clk),
    .rst    (rst),
    .re     (re),
    .r_addr (r_addr),
    .dout   (dout),
    .we     (we),
    .w_addr (w_addr),
    .din    (din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: dout=%h expected=%h", name, got, want);
    end
  endtask

  // One clock cycle of stimulus; when obs is set, the dout after this edge is checked.
  task automatic cycle(input logic [3:0] re_v, input logic [31:0] ra,
                       input logic [3:0] we_v, input logic [31:0] wa,
                       input logic [31:0] d, input bit obs,
                       input logic [31:0] exp_v, input string name);
    @(negedge clk);
    re = re_v; r_addr = ra; we = we_v; w_addr = wa; din = d;
    chk = obs;
    if (obs) begin
      exp_q.push_back(exp_v);
      name_q.push_back(name);
    end
  endtask

  task automatic wr(input logic [3:0] we_v, input logic [31:0] wa, input logic [31:0] d);
    cycle(4'h0, 32'h0, we_v, wa, d, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [3:0] re_v, input logic [31:0] ra,
                    input logic [31:0] exp_v, input string name);
    cycle(re_v, ra, 4'h0, 32'h0, 32'h0, 1'b1, exp_v, name);
  endtask

  task automatic idle();
    @(negedge clk);
    re = '0; we = '0; chk = 1'b0;
  endtask

  // Monitor: decoupled from the driver, consumes one queued expectation per observed edge.
  initial begin
    forever begin
      bit          pend;
      logic [31:0] e;
      string       nm;
      @(posedge clk);
      pend = chk;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_underflow: dout=%h expected=none", dout);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, dout, e);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_initial", dout, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Establish a known dout and a preloaded word before exercising reset.
    wr(4'hF, 32'h14, 32'h1122_3344);
    wr(4'hF, 32'h20, 32'hDEAD_BEEF);
    rd(4'hF, 32'h20, 32'hDEAD_BEEF, "pre_reset_read");
    idle();

    // Asynchronous reset mid-cycle, with a write and read presented during reset.
    #2 rst = 1'b0;
    #1 check("reset_async_clear", dout, 32'h0);
    cycle(4'hF, 32'h14, 4'hF, 32'h14, 32'hFFFF_FFFF, 1'b1, 32'h0, "reset_read_ignored");
    @(negedge clk);
    rst = 1'b1; re = '0; we = '0; chk = 1'b0;
    rd(4'hF, 32'h14, 32'h1122_3344, "mem_survives_reset");

    // Full word write then read.
    wr(4'hF, 32'h40, 32'hA5A5_0F0F);
    rd(4'hF, 32'h40, 32'hA5A5_0F0F, "full_word");

    // Byte lanes.
    wr(4'hF, 32'h10, 32'h0000_0000);
    wr(4'b0100, 32'h10, 32'h00CC_0000);
    rd(4'b0110, 32'h10, 32'h00CC_0000, "lane_write_read");
    rd(4'b0001, 32'h10, 32'h0000_0000, "lane_masked_read");
    wr(4'b1001, 32'h10, 32'h1234_5678);
    rd(4'hF, 32'h10, 32'h12CC_0078, "lane_merge");

    // Write-first forwarding.
    wr(4'hF, 32'hC, 32'h1111_1111);
    cycle(4'hF, 32'hC, 4'b0011, 32'hC, 32'h0000_2222, 1'b1, 32'h1111_2222, "write_first");
    rd(4'hF, 32'hC, 32'h1111_2222, "write_first_stored");
    wr(4'hF, 32'h50, 32'h0000_0000);
    cycle(4'b0011, 32'h50, 4'hF, 32'h50, 32'hAABB_CCDD, 1'b1, 32'h0000_CCDD, "write_first_lane_mask");
    wr(4'hF, 32'h64, 32'h5555_6666);
    cycle(4'hF, 32'h64, 4'hF, 32'h60, 32'h9999_9999, 1'b1, 32'h5555_6666, "no_fwd_diff_word");

    // Alignment and wrap.
    wr(4'hF, 32'h0000_0001, 32'h0000_0007);
    rd(4'hF, 32'h0001_0000, 32'h0000_0007, "wrap_read_word0");
    rd(4'hF, 32'h0000_0003, 32'h0000_0007, "unaligned_read_word0");
    wr(4'hF, 32'hFFFF_FFFC, 32'h0BAD_F00D);
    rd(4'hF, 32'h0000_FFFC, 32'h0BAD_F00D, "wrap_top_word");

    // Hold while re=0 and writes continue, including to the held word.
    wr(4'hF, 32'h30, 32'hCAFE_F00D);
    rd(4'hF, 32'h30, 32'hCAFE_F00D, "hold_setup");
    for (int i = 0; i < 5; i++)
      cycle(4'h0, 32'h30, 4'hF, 32'h30, 32'h100 + i, 1'b1, 32'hCAFE_F00D, "hold");
    rd(4'hF, 32'h30, 32'h0000_0104, "after_hold");
    idle();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
